// File: rtl/wb_arb_pkg.sv
// Shared defines for the register-file write-port arbiter: widths, reserved
// register, write-enable level, JTAG state encodings and starve limit.
package wb_arb_pkg;
  localparam int unsigned DW_DEF           = 32;
  localparam int unsigned AW_DEF           = 5;
  localparam int unsigned ZERO_REG         = 0;
  localparam logic        WRITE_ENABLE     = 1'b1;
  localparam int unsigned STARVE_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    JTAG_IDLE = 2'd0,
    JTAG_WAIT = 2'd1,
    JTAG_ACK  = 2'd2
  } jtag_state_e;
endpackage

// File: rtl/wb_skid.sv
// One-entry skid buffer holding a divider result that lost the write port to EX.
module wb_skid
  import wb_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: EX > skid > divider > JTAG, with a divide
// scoreboard for RAW stalls and a starve-driven pipeline hold for JTAG.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_we_i,
  input  logic [AW-1:0] ex_waddr_i,
  input  logic [DW-1:0] ex_wdata_i,
  input  logic          div_start_i,
  input  logic [AW-1:0] div_rd_i,
  input  logic          div_valid_i,
  input  logic [AW-1:0] div_waddr_i,
  input  logic [DW-1:0] div_wdata_i,
  output logic          div_ready_o,
  input  logic          jtag_req_i,
  input  logic [AW-1:0] jtag_addr_i,
  input  logic [DW-1:0] jtag_wdata_i,
  output logic          jtag_ack_o,
  input  logic [AW-1:0] id_raddr1_i,
  input  logic [AW-1:0] id_raddr2_i,
  output logic          stall_o,
  output logic          hold_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [DW-1:0] wdata_o
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic          ex_wr, accept, buf_load, buf_drain, div_direct, jtag_grant;
  logic          sel_we, div_commit;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  jtag_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_rd_q, pend_rd_d;

  // An EX write to x0 does not occupy the port, so the divider may go direct.
  assign ex_wr       = ex_we_i && (ex_waddr_i != ZR);
  assign div_ready_o = ~buf_valid;
  assign accept      = div_valid_i & ~buf_valid;
  assign buf_load    = accept & ex_wr;
  assign buf_drain   = buf_valid & ~ex_wr;
  assign div_direct  = accept & ~ex_wr;
  assign jtag_grant  = (state_q == JTAG_WAIT) & jtag_req_i & ~ex_wr & ~buf_valid & ~accept;

  wb_skid #(.DW(DW), .AW(AW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .addr_i  (div_waddr_i),
    .data_i  (div_wdata_i),
    .valid_o (buf_valid),
    .addr_o  (buf_addr),
    .data_o  (buf_data)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (ex_wr) begin
      sel_we = WRITE_ENABLE; sel_addr = ex_waddr_i; sel_data = ex_wdata_i;
    end else if (buf_valid) begin
      sel_we = WRITE_ENABLE; sel_addr = buf_addr; sel_data = buf_data;
    end else if (accept) begin
      sel_we = WRITE_ENABLE; sel_addr = div_waddr_i; sel_data = div_wdata_i;
    end else if (jtag_grant) begin
      sel_we = WRITE_ENABLE; sel_addr = jtag_addr_i; sel_data = jtag_wdata_i;
    end
  end

  assign we_o    = sel_we && (sel_addr != ZR) && !rst;
  assign waddr_o = sel_addr;
  assign wdata_o = sel_data;

  // Scoreboard: pend_rd is never zero, so x0 results cannot clear it.
  assign div_commit = pend_valid_q &
                      ((buf_drain & (buf_addr == pend_rd_q)) |
                       (div_direct & (div_waddr_i == pend_rd_q)));

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    if (div_commit) pend_valid_d = 1'b0;
    if (div_start_i && (div_rd_i != ZR)) begin
      pend_valid_d = 1'b1;
      pend_rd_d    = div_rd_i;
    end
  end

  assign stall_o = pend_valid_q & ((id_raddr1_i == pend_rd_q) | (id_raddr2_i == pend_rd_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    hold_d  = 1'b0;
    case (state_q)
      JTAG_IDLE: if (jtag_req_i) state_d = JTAG_WAIT;
      JTAG_WAIT: begin
        if (!jtag_req_i)     state_d = JTAG_IDLE;
        else if (jtag_grant) state_d = JTAG_ACK;
        cnt_d = (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + 1'b1;
      end
      JTAG_ACK:  if (!jtag_req_i) state_d = JTAG_IDLE;
      default:   state_d = JTAG_IDLE;
    endcase
    if (state_d != JTAG_WAIT) cnt_d = '0;
    hold_d = (state_d == JTAG_WAIT) && (cnt_d == CW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= JTAG_IDLE;
      cnt_q        <= '0;
      hold_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
    end
  end

  assign jtag_ack_o = (state_q == JTAG_ACK) && !rst;
  assign hold_o     = hold_q && !rst;
endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios then random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_wb_arb;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ex_we, div_start, div_valid, jtag_req;
  logic [AW-1:0] ex_waddr, div_rd, div_waddr, jtag_addr, id_raddr1, id_raddr2;
  logic [DW-1:0] ex_wdata, div_wdata, jtag_wdata;
  logic          div_ready_o, jtag_ack_o, stall_o, hold_o, we_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;

  wb_arb #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .div_start_i(div_start), .div_rd_i(div_rd),
    .div_valid_i(div_valid), .div_waddr_i(div_waddr), .div_wdata_i(div_wdata),
    .div_ready_o(div_ready_o),
    .jtag_req_i(jtag_req), .jtag_addr_i(jtag_addr), .jtag_wdata_i(jtag_wdata),
    .jtag_ack_o(jtag_ack_o),
    .id_raddr1_i(id_raddr1), .id_raddr2_i(id_raddr2), .stall_o(stall_o),
    .hold_o(hold_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  // Model: pending divider results waiting for the port, scoreboard entry,
  // JTAG phase (0 idle, 1 waiting, 2 acked) and cycles spent waiting.
  logic [AW+DW-1:0] sq[$];
  bit               m_pv;
  logic [AW-1:0]    m_prd;
  int               m_jph, m_wc;
  bit               m_hold;
  int               checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit ex_real, acc, jg, pw, exp_we, dc;
    logic [AW-1:0] pa, dca;
    logic [DW-1:0] pd;
    @(negedge clk);
    ex_real = ex_we && (ex_waddr != 0);
    acc     = div_valid && (sq.size() == 0);
    jg = 0; pw = 0; pa = '0; pd = '0; dc = 0; dca = '0;
    if (ex_real) begin
      pw = 1; pa = ex_waddr; pd = ex_wdata;
    end else if (sq.size() > 0) begin
      pw = 1; {pa, pd} = sq[0]; dc = 1; dca = pa;
    end else if (acc) begin
      pw = 1; pa = div_waddr; pd = div_wdata; dc = 1; dca = pa;
    end else if (m_jph == 1 && jtag_req) begin
      jg = 1; pw = 1; pa = jtag_addr; pd = jtag_wdata;
    end
    exp_we = pw && (pa != 0) && !rst;
    chk("we", we_o, exp_we);
    if (exp_we) begin
      chk("waddr", waddr_o, pa);
      chk("wdata", wdata_o, pd);
    end
    chk("div_ready", div_ready_o, sq.size() == 0);
    chk("stall", stall_o, m_pv && (id_raddr1 == m_prd || id_raddr2 == m_prd));
    chk("ack", jtag_ack_o, !rst && m_jph == 2);
    chk("hold", hold_o, !rst && m_hold);
    @(posedge clk);
    if (rst) begin
      sq.delete(); m_pv = 0; m_prd = '0; m_jph = 0; m_wc = 0; m_hold = 0;
    end else begin
      if (m_pv && dc && dca == m_prd) m_pv = 0;
      if (div_start && div_rd != 0) begin m_pv = 1; m_prd = div_rd; end
      if (!ex_real && sq.size() > 0) void'(sq.pop_front());
      if (acc && ex_real) sq.push_back({div_waddr, div_wdata});
      m_hold = 0;
      case (m_jph)
        0: if (jtag_req) begin m_jph = 1; m_wc = 0; end
        1: begin
          if (!jtag_req) m_jph = 0;
          else if (jg)   m_jph = 2;
          else begin m_wc++; m_hold = (m_wc >= LIM); end
        end
        default: if (!jtag_req) m_jph = 0;
      endcase
    end
    #1;
  endtask

  task automatic idle_inputs();
    ex_we = 0; ex_waddr = '0; ex_wdata = '0;
    div_start = 0; div_rd = '0; div_valid = 0; div_waddr = '0; div_wdata = '0;
    jtag_req = 0; jtag_addr = '0; jtag_wdata = '0;
    id_raddr1 = '0; id_raddr2 = '0;
  endtask

  initial begin
    m_pv = 0; m_prd = '0; m_jph = 0; m_wc = 0; m_hold = 0;
    rst = 1; idle_inputs();
    #1;
    cycle(); cycle();
    rst = 0;
    chk("rst_ready", div_ready_o, 1'b1);
    chk("rst_hold", hold_o, 1'b0);
    chk("rst_ack", jtag_ack_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);

    // EX and divider collide: EX wins now, divider follows from the skid.
    ex_we = 1; ex_waddr = 5; ex_wdata = 32'h11;
    div_valid = 1; div_waddr = 6; div_wdata = 32'h22;
    #1; chk("t30_c0_addr", waddr_o, 5); chk("t30_c0_data", wdata_o, 32'h11);
    cycle();
    idle_inputs();
    #1; chk("t30_ready", div_ready_o, 1'b0);
    chk("t30_c1_addr", waddr_o, 6); chk("t30_c1_data", wdata_o, 32'h22);
    cycle(); cycle();

    // RAW stall on a pending divide to x7.
    div_start = 1; div_rd = 7; id_raddr2 = 7;
    cycle();
    div_start = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t31_stall", stall_o, 1'b1);
    div_valid = 1; div_waddr = 7; div_wdata = 32'h77;
    cycle();
    div_valid = 0;
    #1; chk("t31_clear", stall_o, 1'b0);
    id_raddr2 = 0;
    cycle();

    // x0 divider result: handshake only, scoreboard for x9 kept.
    div_start = 1; div_rd = 9; cycle();
    div_start = 0; div_valid = 1; div_waddr = 0; div_wdata = 32'h5; id_raddr1 = 9;
    #1; chk("t33_we", we_o, 1'b0); chk("t33_ready", div_ready_o, 1'b1);
    cycle();
    div_valid = 0;
    #1; chk("t33_stall", stall_o, 1'b1);
    div_valid = 1; div_waddr = 9; div_wdata = 32'h99; cycle();
    div_valid = 0; id_raddr1 = 0; cycle();

    // JTAG starved by 20 cycles of EX writes.
    jtag_req = 1; jtag_addr = 3; jtag_wdata = 32'hDEADBEEF; ex_we = 1;
    for (int c = 0; c < 20; c++) begin
      ex_waddr = AW'(1 + c % 4); ex_wdata = $urandom;
      #1; chk("t32_hold", hold_o, c >= 17);
      cycle();
    end
    ex_we = 0;
    #1; chk("t32_we", we_o, 1'b1); chk("t32_addr", waddr_o, 3); chk("t32_data", wdata_o, 32'hDEADBEEF);
    cycle();
    chk("t32_ack", jtag_ack_o, 1'b1);
    jtag_req = 0; cycle(); cycle();

    // Reset with a full skid buffer and JTAG waiting.
    ex_we = 1; ex_waddr = 2; ex_wdata = 32'h2; div_valid = 1; div_waddr = 4; div_wdata = 32'h4;
    jtag_req = 1; jtag_addr = 8; jtag_wdata = 32'h8;
    cycle();
    ex_we = 0; div_valid = 0; rst = 1;
    cycle();
    rst = 0; jtag_req = 0;
    chk("t34_ready", div_ready_o, 1'b1); chk("t34_hold", hold_o, 1'b0); chk("t34_ack", jtag_ack_o, 1'b0);
    chk("t34_we", we_o, 1'b0);
    cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      ex_we     = ((i % 100) < 40) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      ex_waddr  = AW'($urandom_range(0, 7)); ex_wdata = $urandom;
      div_valid = ($urandom_range(0, 2) == 0);
      div_waddr = AW'($urandom_range(0, 7)); div_wdata = $urandom;
      div_start = ($urandom_range(0, 7) == 0); div_rd = AW'($urandom_range(0, 7));
      id_raddr1 = AW'($urandom_range(0, 7)); id_raddr2 = AW'($urandom_range(0, 7));
      if (m_jph == 2) jtag_req = 0;
      else if (!jtag_req) begin
        jtag_req   = ($urandom_range(0, 7) == 0);
        jtag_addr  = AW'($urandom_range(0, 7));
        jtag_wdata = $urandom;
      end else if ($urandom_range(0, 49) == 0) jtag_req = 0;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter DW, 32, register data width (matches RegBus).
REQ-002 SHALL have parameter AW, 5, register address width (matches RegAddrBus).
REQ-003 SHALL have parameter STARVE_LIMIT, 16, JTAG wait cycles before hold request.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ex_we_i / ex_waddr_i / ex_wdata_i  in  1/AW/DW  single-cycle EX writeback, never stalled.
REQ-007 div_start_i / div_rd_i  in  1/AW  divide issued to destination rd.
REQ-008 div_valid_i / div_waddr_i / div_wdata_i  in  1/AW/DW  divider result; div_ready_o  out  1  result accepted.
REQ-009 jtag_req_i / jtag_addr_i / jtag_wdata_i  in  1/AW/DW  debug write request (4-phase); jtag_ack_o  out  1  write committed.
REQ-010 id_raddr1_i / id_raddr2_i  in  AW/AW  ID read addresses; stall_o  out  1  RAW hazard on pending divide.
REQ-011 hold_o  out  1  registered pipeline-hold request for starved JTAG.
REQ-012 we_o / waddr_o / wdata_o  out  1/AW/DW  single write port into register file.

Function
REQ-013 Write-port priority SHALL be: EX > skid buffer > direct divider result > JTAG.
REQ-014 EX path SHALL be combinational pass-through, zero latency, so register-file forwarding is preserved.
REQ-015 div_ready_o SHALL equal NOT buf_valid; accept = div_valid_i AND div_ready_o.
REQ-016 On accept with no EX write (ex_we_i low or ex_waddr_i zero) the result SHALL drive the port the same cycle; otherwise it SHALL be captured into the one-entry skid buffer.
REQ-017 A valid buffer SHALL drain on the first cycle without an EX write; buf_valid clears that edge.
REQ-018 Any source with address 0 SHALL produce we_o low but still complete its handshake.
REQ-019 Scoreboard (pend_valid, pend_rd) SHALL set on div_start_i with div_rd_i nonzero and clear when the divider write to pend_rd is committed on the port; set wins over simultaneous clear.
REQ-020 stall_o SHALL be pend_valid AND (id_raddr1_i == pend_rd OR id_raddr2_i == pend_rd), combinational.
REQ-021 One divide outstanding; div_start_i while pend_valid SHALL overwrite pend_rd.
REQ-022 JTAG FSM states IDLE, WAIT, ACK: IDLE->WAIT on jtag_req_i; WAIT->ACK on first cycle no higher-priority source writes, JTAG write driven that cycle; ACK->IDLE when jtag_req_i low.
REQ-023 jtag_ack_o SHALL be high exactly in state ACK (registered, one cycle after the write).
REQ-024 Starve counter SHALL count cycles in WAIT, saturate at STARVE_LIMIT; hold_o SHALL assert the cycle after count reaches STARVE_LIMIT and deassert the cycle after leaving WAIT.
REQ-025 jtag_req_i dropped while in WAIT SHALL return FSM to IDLE with no write.

Reset
REQ-026 rst SHALL clear buf_valid, pend_valid, starve counter, FSM to IDLE; jtag_ack_o, hold_o, div_ready_o(after reset: 1), we_o low during reset.
REQ-027 Reset mid-handshake SHALL discard buffered divider data and pending JTAG request; master re-issues.

Structure
REQ-028 DW/AW widths, ZeroReg, WriteEnable, JTAG state encodings and STARVE_LIMIT default SHALL live in the shared defines package.
REQ-029 Skid buffer SHALL be one sub-module, wb_skid (valid/data/addr register with load/drain).

Verification
REQ-030 EX write x5=0x11 with div_valid x6=0x22 same cycle -> cycle0 port x5/0x11, cycle1 port x6/0x22, div_ready_o low cycle1.
REQ-031 div_start rd=x7, id_raddr2=x7 -> stall_o high until cycle div write x7 commits, low next cycle.
REQ-032 jtag_req x3=0xDEADBEEF under 20 cycles continuous EX writes -> hold_o high from WAIT cycle 17; write when EX idle; jtag_ack_o one cycle later.
REQ-033 div_valid to x0 -> we_o low, div_ready_o handshake completes, scoreboard untouched.
REQ-034 rst asserted with buf_valid and FSM in WAIT -> next cycle buf empty, FSM IDLE, hold_o/jtag_ack_o low, no write issued.
